me_search_ctrl: RTL and testbench

Full-search motion-estimation controller for the inter-prediction path. It consumes the stream of per-candidate SAD values from the PE-matrix/sum-tree datapath in raster candidate order. It tracks the best candidate with a zero-MV-biased tie-break and optional early termination, then reports the minimum SAD and signed motion vector with a one-cycle done pulse. It succeeds the fixed 16/48 min-SAD comparator with parametrised window geometry, candidate tracking, MV output and search control.

---
 rtl/me_search_ctrl.sv | 135 +++++++++++++
 tb/tb_me_search_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion-estimation controller (best SAD + signed MV)
module me_search_ctrl #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 7,
  localparam int N         = SEARCH_DIM - MACRO_DIM + 1,
  localparam int CW        = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              early_en,
  input  logic [SAD_W-1:0]  thresh,
  input  logic              sad_valid,
  input  logic [SAD_W-1:0]  sad_in,
  output logic              busy,
  output logic [CW-1:0]     cand_x,
  output logic [CW-1:0]     cand_y,
  output logic              done,
  output logic              early_term,
  output logic [SAD_W-1:0]  min_sad,
  output logic [MV_W-1:0]   mv_x,
  output logic [MV_W-1:0]   mv_y
);

  localparam int            RANGE   = (N - 1) / 2;
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [CW-1:0] RANGE_C = CW'(RANGE);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cx, cy;
  logic [CW-1:0]     best_cx, best_cy;
  logic [SAD_W-1:0]  best_sad;
  logic [CW:0]       best_norm;
  logic [SAD_W-1:0]  thresh_q;
  logic              early_en_q;

  logic [CW-1:0]     dist_x, dist_y;
  logic [CW:0]       norm;
  logic              accept, better, early_hit, last_cand, finish;
  logic [SAD_W-1:0]  new_sad;
  logic [CW-1:0]     new_cx, new_cy;
  logic signed [CW:0] dx, dy;

  // Candidate evaluation: distance from the zero MV, tie-break compare and termination decision.
  always_comb begin
    dist_x    = (cx >= RANGE_C) ? (cx - RANGE_C) : (RANGE_C - cx);
    dist_y    = (cy >= RANGE_C) ? (cy - RANGE_C) : (RANGE_C - cy);
    norm      = {1'b0, dist_x} + {1'b0, dist_y};
    accept    = (state == SEARCH) && sad_valid;
    better    = (sad_in < best_sad) || ((sad_in == best_sad) && (norm < best_norm));
    early_hit = early_en_q && (sad_in < thresh_q);
    last_cand = (cx == LAST) && (cy == LAST);
    finish    = accept && (early_hit || last_cand);
    new_sad   = better ? sad_in : best_sad;
    new_cx    = better ? cx     : best_cx;
    new_cy    = better ? cy     : best_cy;
    dx        = $signed({1'b0, new_cx}) - $signed({1'b0, RANGE_C});
    dy        = $signed({1'b0, new_cy}) - $signed({1'b0, RANGE_C});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start only counts in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)  state_nx = SEARCH;
      SEARCH:  if (finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Search datapath: raster counters, running best, and result registers loaded on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx         <= '0;
      cy         <= '0;
      best_cx    <= '0;
      best_cy    <= '0;
      best_sad   <= '0;
      best_norm  <= '0;
      thresh_q   <= '0;
      early_en_q <= 1'b0;
      early_term <= 1'b0;
      min_sad    <= '0;
      mv_x       <= '0;
      mv_y       <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        cx         <= '0;
        cy         <= '0;
        early_term <= 1'b0;
        best_sad   <= '1;
        best_norm  <= '1;
        thresh_q   <= thresh;
        early_en_q <= early_en;
      end
      if (accept) begin
        if (better) begin
          best_sad  <= sad_in;
          best_norm <= norm;
          best_cx   <= cx;
          best_cy   <= cy;
        end
        if (cx == LAST) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
      if (finish) begin
        min_sad    <= new_sad;
        mv_x       <= MV_W'(dx);
        mv_y       <= MV_W'(dy);
        early_term <= early_hit;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign cand_x = (state == SEARCH) ? cx : '0;
  assign cand_y = (state == SEARCH) ? cy : '0;

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - randomized self-checking bench for me_search_ctrl
module tb_me_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, early_en, sad_valid, sel;
  logic [15:0] thresh, sad_in;

  logic        busy_a, done_a, early_a, busy_b, done_b, early_b;
  logic [5:0]  cx_a, cy_a;
  logic [4:0]  cx_b, cy_b;
  logic [15:0] min_a, min_b;
  logic [6:0]  mvx_a, mvy_a, mvx_b, mvy_b;

  me_search_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .early_en(early_en), .thresh(thresh),
    .sad_valid(sad_valid & ~sel), .sad_in(sad_in), .busy(busy_a), .cand_x(cx_a),
    .cand_y(cy_a), .done(done_a), .early_term(early_a), .min_sad(min_a),
    .mv_x(mvx_a), .mv_y(mvy_a)
  );

  me_search_ctrl #(.MACRO_DIM(8), .SEARCH_DIM(24)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .early_en(early_en), .thresh(thresh),
    .sad_valid(sad_valid & sel), .sad_in(sad_in), .busy(busy_b), .cand_x(cx_b),
    .cand_y(cy_b), .done(done_b), .early_term(early_b), .min_sad(min_b),
    .mv_x(mvx_b), .mv_y(mvy_b)
  );

  wire        busy_m  = sel ? busy_b  : busy_a;
  wire        done_m  = sel ? done_b  : done_a;
  wire        early_m = sel ? early_b : early_a;
  wire [5:0]  cx_m    = sel ? {1'b0, cx_b} : cx_a;
  wire [5:0]  cy_m    = sel ? {1'b0, cy_b} : cy_a;
  wire [15:0] min_m   = sel ? min_b : min_a;
  wire [6:0]  mvx_m   = sel ? mvx_b : mvx_a;
  wire [6:0]  mvy_m   = sel ? mvy_b : mvy_a;

  int checks = 0;
  int failures = 0;

  logic        chk_en;
  logic        exp_busy, exp_done, exp_early;
  logic [5:0]  exp_cx, exp_cy;
  logic [15:0] exp_min;
  logic [6:0]  exp_mvx, exp_mvy;
  logic [15:0] h_min [2];
  logic [6:0]  h_mvx [2];
  logic [6:0]  h_mvy [2];
  logic        h_early [2];

  int sad_arr [0:1088];
  int n;
  int m_min, m_mvx, m_mvy, m_count;
  bit m_early;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [6:0] mv7(input int v);
    logic [31:0] t;
    t = v;
    return t[6:0];
  endfunction

  // Per-cycle comparison of every DUT output against the bench's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       32'(busy_m),  32'(exp_busy));
      chk("done",       32'(done_m),  32'(exp_done));
      chk("early_term", 32'(early_m), 32'(exp_early));
      chk("cand_x",     32'(cx_m),    32'(exp_cx));
      chk("cand_y",     32'(cy_m),    32'(exp_cy));
      chk("min_sad",    32'(min_m),   32'(exp_min));
      chk("mv_x",       32'(mvx_m),   32'(exp_mvx));
      chk("mv_y",       32'(mvy_m),   32'(exp_mvy));
    end
  end

  task automatic set_idle_exp();
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    exp_cx    = '0;
    exp_cy    = '0;
    exp_min   = h_min[sel];
    exp_mvx   = h_mvx[sel];
    exp_mvy   = h_mvy[sel];
    exp_early = h_early[sel];
  endtask

  task automatic clear_holds();
    for (int i = 0; i < 2; i++) begin
      h_min[i] = '0; h_mvx[i] = '0; h_mvy[i] = '0; h_early[i] = 1'b0;
    end
  endtask

  // Reference: smallest SAD wins, ties go to the smallest |dx|+|dy|, then to the earliest in raster order.
  task automatic model_run(input bit ee, input int thr);
    int r, bs, bn, bx, by, x, y, nm, k;
    r = (n - 1) / 2;
    bs = -1; bn = 0; bx = 0; by = 0;
    m_early = 1'b0;
    for (k = 0; k < n * n; k++) begin
      x = k % n;
      y = k / n;
      nm = ((x > r) ? x - r : r - x) + ((y > r) ? y - r : r - y);
      if (bs < 0 || sad_arr[k] < bs || (sad_arr[k] == bs && nm < bn)) begin
        bs = sad_arr[k]; bn = nm; bx = x; by = y;
      end
      if (ee && sad_arr[k] < thr) begin
        m_early = 1'b1;
        break;
      end
    end
    m_count = m_early ? k + 1 : n * n;
    m_min = bs;
    m_mvx = bx - r;
    m_mvy = by - r;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 1089; i++) sad_arr[i] = v;
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < 1089; i++) sad_arr[i] = $urandom_range(hi, 0);
  endtask

  task automatic run_search(input bit ee, input int thr, input bit gaps, input int abort_at);
    int  k;
    bit  v;
    model_run(ee, thr);
    @(posedge clk); #1;
    start = 1'b1; early_en = ee; thresh = 16'(thr);
    sad_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b0;
    sad_in = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    h_early[sel] = 1'b0;
    exp_early = 1'b0;
    k = 0;
    while (k < m_count) begin
      v = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      exp_busy = 1'b1; exp_done = 1'b0;
      exp_cx = 6'(k % n); exp_cy = 6'(k / n);
      if (k == abort_at) begin
        rst = 1'b1; sad_valid = 1'b1; sad_in = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0; sad_valid = 1'b0;
        clear_holds();
        set_idle_exp();
        return;
      end
      sad_valid = v;
      sad_in = v ? 16'(sad_arr[k]) : 16'($urandom);
      start = gaps ? 1'($urandom_range(1, 0)) : 1'b0;
      @(posedge clk); #1;
      if (v) k++;
    end
    h_min[sel] = 16'(m_min);
    h_mvx[sel] = mv7(m_mvx);
    h_mvy[sel] = mv7(m_mvy);
    h_early[sel] = m_early;
    set_idle_exp();
    exp_busy = 1'b1; exp_done = 1'b1;
    sad_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b0;
    start = gaps;
    @(posedge clk); #1;
    start = 1'b0; sad_valid = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; early_en = 1'b0; sad_valid = 1'b0;
    thresh = '0; sad_in = '0; chk_en = 1'b0; n = 33;
    clear_holds();
    set_idle_exp();
    @(posedge clk); #1;
    chk_en = 1'b1;
    start = 1'b1; sad_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; sad_valid = 1'b0;
    @(posedge clk); #1;

    fill(500); sad_arr[12*33+20] = 37;
    run_search(1'b0, 0, 1'b0, -1);
    chk("t1_min", 32'(min_m), 32'd37);
    chk("t1_mvx", 32'(mvx_m), 32'(mv7(4)));
    chk("t1_mvy", 32'(mvy_m), 32'(mv7(-4)));
    chk("t1_count", 32'(m_count), 32'd1089);

    fill(200); sad_arr[0] = 10; sad_arr[16*33+16] = 10; sad_arr[32*33+32] = 10;
    run_search(1'b0, 0, 1'b0, -1);
    chk("t2a_min", 32'(min_m), 32'd10);
    chk("t2a_mvx", 32'(mvx_m), 32'(mv7(0)));
    chk("t2a_mvy", 32'(mvy_m), 32'(mv7(0)));

    fill(200); sad_arr[16*33+3] = 10; sad_arr[16*33+29] = 10;
    run_search(1'b0, 0, 1'b0, -1);
    chk("t2b_mvx", 32'(mvx_m), 32'(mv7(-13)));
    chk("t2b_mvy", 32'(mvy_m), 32'(mv7(0)));

    fill(100); sad_arr[2*33+5] = 7;
    run_search(1'b1, 8, 1'b0, -1);
    chk("t3a_count", 32'(m_count), 32'd72);
    chk("t3a_early", 32'(early_m), 32'd1);
    chk("t3a_min", 32'(min_m), 32'd7);
    chk("t3a_mvx", 32'(mvx_m), 32'(mv7(-11)));
    chk("t3a_mvy", 32'(mvy_m), 32'(mv7(-14)));

    sad_arr[2*33+5] = 8;
    run_search(1'b1, 8, 1'b0, -1);
    chk("t3b_count", 32'(m_count), 32'd1089);
    chk("t3b_early", 32'(early_m), 32'd0);
    chk("t3b_min", 32'(min_m), 32'd8);

    fill(500); sad_arr[12*33+20] = 37;
    run_search(1'b0, 0, 1'b1, -1);
    chk("t4_min", 32'(min_m), 32'd37);
    chk("t4_mvx", 32'(mvx_m), 32'(mv7(4)));
    chk("t4_mvy", 32'(mvy_m), 32'(mv7(-4)));

    fill_rand(255);
    run_search(1'b0, 0, 1'b0, 500);
    chk("t5_rst_min", 32'(min_m), 32'd0);
    fill(16'hFFFF);
    run_search(1'b0, 0, 1'b0, -1);
    chk("t5_min", 32'(min_m), 32'hFFFF);
    chk("t5_mvx", 32'(mvx_m), 32'(mv7(0)));
    chk("t5_mvy", 32'(mvy_m), 32'(mv7(0)));

    for (int r = 0; r < 4; r++) begin
      fill_rand(63);
      run_search(1'($urandom_range(1, 0)), int'($urandom_range(6, 0)), 1'($urandom_range(1, 0)), -1);
    end

    sel = 1'b1; n = 17;
    set_idle_exp();
    fill(300); sad_arr[16*17+0] = 5;
    run_search(1'b0, 0, 1'b0, -1);
    chk("t6_count", 32'(m_count), 32'd289);
    chk("t6_min", 32'(min_m), 32'd5);
    chk("t6_mvx", 32'(mvx_m), 32'(mv7(-8)));
    chk("t6_mvy", 32'(mvy_m), 32'(mv7(8)));
    fill_rand(31);
    run_search(1'b1, 2, 1'b1, -1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
